// File: rtl/majority_pkg.sv
// Shared constants and helpers for the N-channel majority voter.
// Used by majority_bit and majority_voter_n.
package majority_pkg;

    localparam int MAJ_N_CH_DEF      = 3;
    localparam int MAJ_WIDTH_DEF     = 8;
    localparam int MAJ_ERR_LIMIT_DEF = 4;

    // Bits needed to hold values 0 .. v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Low bit index of channel ch in a packed bus of w-bit words.
    function automatic int ch_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/majority_voter_n_bit.sv
// Combinational popcount-compare vote for one bit slice across all channels.
// An exact tie among active channels (including none active) returns hold_i.
module majority_bit
    import majority_pkg::*;
#(
    parameter int N_CH = MAJ_N_CH_DEF
) (
    input  logic [N_CH-1:0] votes_i,
    input  logic [N_CH-1:0] mask_i,
    input  logic            hold_i,
    output logic            vote_o
);

    localparam int PW = clog2(N_CH + 1);

    logic [PW-1:0] ones;
    logic [PW-1:0] active;
    logic [PW-1:0] half;

    always_comb begin
        ones   = '0;
        active = '0;
        for (int i = 0; i < N_CH; i++) begin
            ones   = ones + PW'(votes_i[i] & mask_i[i]);
            active = active + PW'(mask_i[i]);
        end
        half   = active >> 1;
        vote_o = 1'b0;
        if (ones > half) begin
            vote_o = 1'b1;
        end else if (!active[0] && (ones == half)) begin
            vote_o = hold_i;
        end
    end

endmodule

// File: rtl/majority_voter_n.sv
// Registered N-channel bitwise majority voter with per-channel sticky faults.
// Define MAJORITY_VOTER_MASK_EN to drop faulted channels from the vote.
module majority_voter_n
    import majority_pkg::*;
#(
    parameter int N_CH      = MAJ_N_CH_DEF,
    parameter int WIDTH     = MAJ_WIDTH_DEF,
    parameter int ERR_LIMIT = MAJ_ERR_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [N_CH*WIDTH-1:0] ch_data,
    input  logic                  clr_fault,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      major_data,
    output logic [N_CH-1:0]       mismatch,
    output logic                  all_agree,
    output logic [N_CH-1:0]       fault
);

    localparam int CW = clog2(ERR_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(ERR_LIMIT);

    logic [WIDTH-1:0] words    [N_CH];
    logic [N_CH-1:0]  bit_vote [WIDTH];
    logic [N_CH-1:0]  vote_mask;
    logic [WIDTH-1:0] vote_d;
    logic [N_CH-1:0]  mismatch_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] major_q;
    logic [N_CH-1:0]  mismatch_q;
    logic             agree_q;
    logic [N_CH-1:0]  fault_q;
    logic [N_CH-1:0]  fault_d;
    logic [CW-1:0]    cnt_q [N_CH];
    logic [CW-1:0]    cnt_d [N_CH];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            words[i] = ch_data[ch_lo(i, WIDTH) +: WIDTH];
        end
    end

    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            for (int i = 0; i < N_CH; i++) begin
                bit_vote[b][i] = words[i][b];
            end
        end
    end

`ifdef MAJORITY_VOTER_MASK_EN
    assign vote_mask = ~fault_q;
`else
    assign vote_mask = '1;
`endif

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        majority_bit #(
            .N_CH (N_CH)
        ) u_bit (
            .votes_i (bit_vote[b]),
            .mask_i  (vote_mask),
            .hold_i  (major_q[b]),
            .vote_o  (vote_d[b])
        );
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            mismatch_d[i] = (words[i] != vote_d);
        end
    end

    // Clear beats counting when clr_fault meets a valid sample.
    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (clr_fault) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_d[i] = '0;
            end
            fault_d = '0;
        end else if (in_valid) begin
            for (int i = 0; i < N_CH; i++) begin
                if (mismatch_d[i]) begin
                    if (cnt_q[i] != LIM) begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                    if (cnt_d[i] == LIM) begin
                        fault_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            major_q     <= '0;
            mismatch_q  <= '0;
            agree_q     <= 1'b0;
            fault_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                major_q    <= vote_d;
                mismatch_q <= mismatch_d;
                agree_q    <= ~|mismatch_d;
            end
            fault_q <= fault_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign major_data = major_q;
    assign mismatch   = mismatch_q;
    assign all_agree  = agree_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_majority_voter_n.sv
// Scoreboard bench for majority_voter_n (N_CH=3, WIDTH=8, ERR_LIMIT=4).
// Follows MAJORITY_VOTER_MASK_EN in the same way as the design.
module tb_majority_voter_n;

    localparam int N   = 3;
    localparam int W   = 8;
    localparam int LIM = 4;

    typedef struct {
        bit           v;
        logic [W-1:0] maj;
        logic [N-1:0] mm;
        bit           ag;
        logic [N-1:0] flt;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic [N*W-1:0] ch_data = '0;
    logic           clr_fault = 1'b0;
    logic           out_valid;
    logic [W-1:0]   major_data;
    logic [N-1:0]   mismatch;
    logic           all_agree;
    logic [N-1:0]   fault;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t q[$];

    bit           m_v;
    logic [W-1:0] m_maj;
    logic [N-1:0] m_mm;
    bit           m_ag;
    logic [N-1:0] m_flt;
    int           m_cnt [N];

    always #5 clk = ~clk;

    majority_voter_n #(
        .N_CH      (N),
        .WIDTH     (W),
        .ERR_LIMIT (LIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .ch_data    (ch_data),
        .clr_fault  (clr_fault),
        .out_valid  (out_valid),
        .major_data (major_data),
        .mismatch   (mismatch),
        .all_agree  (all_agree),
        .fault      (fault)
    );

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Reference: count ones per bit among voting channels, strict majority wins.
    function automatic void model(bit v, logic [N*W-1:0] d, bit clr, bit r);
        logic [W-1:0] w [N];
        logic [W-1:0] nm;
        logic [N-1:0] mm;
        int ones, act;
        bit on;
        if (r) begin
            m_v = 0; m_maj = '0; m_mm = '0; m_ag = 0; m_flt = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            return;
        end
        m_v = v;
        mm = m_mm;
        if (v) begin
            for (int i = 0; i < N; i++) w[i] = d[i*W +: W];
            for (int b = 0; b < W; b++) begin
                ones = 0;
                act  = 0;
                for (int i = 0; i < N; i++) begin
`ifdef MAJORITY_VOTER_MASK_EN
                    on = !m_flt[i];
`else
                    on = 1'b1;
`endif
                    if (on) begin
                        act++;
                        ones += int'(w[i][b]);
                    end
                end
                if (2 * ones > act) nm[b] = 1'b1;
                else if (2 * ones == act) nm[b] = m_maj[b];
                else nm[b] = 1'b0;
            end
            for (int i = 0; i < N; i++) mm[i] = (w[i] != nm);
            m_maj = nm;
            m_mm  = mm;
            m_ag  = (mm == '0);
        end
        if (clr) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_flt = '0;
        end else if (v) begin
            for (int i = 0; i < N; i++) begin
                if (mm[i]) begin
                    if (m_cnt[i] < LIM) m_cnt[i]++;
                    if (m_cnt[i] == LIM) m_flt[i] = 1'b1;
                end else begin
                    m_cnt[i] = 0;
                end
            end
        end
    endfunction

    task automatic drive(bit v, logic [N*W-1:0] d, bit clr, bit r);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        ch_data   = d;
        clr_fault = clr;
        rst       = r;
        model(v, d, clr, r);
        e.v = m_v; e.maj = m_maj; e.mm = m_mm; e.ag = m_ag; e.flt = m_flt;
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_valid", 32'(out_valid), 32'(e.v));
            chk("sb_major", 32'(major_data), 32'(e.maj));
            chk("sb_mismatch", 32'(mismatch), 32'(e.mm));
            chk("sb_agree", 32'(all_agree), 32'(e.ag));
            chk("sb_fault", 32'(fault), 32'(e.flt));
        end
    end

    localparam logic [N*W-1:0] BAD  = {8'hC3, 8'h3C, 8'h3C};
    localparam logic [N*W-1:0] GOOD = {8'h3C, 8'h3C, 8'h3C};

    initial begin
        logic [N*W-1:0] d;
        logic [W-1:0]   base;
        int             sick;

        drive(1'($urandom), 24'($urandom), 1'b0, 1'b1);
        drive(1'($urandom), 24'($urandom), 1'b0, 1'b1);
        settle();
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_major", 32'(major_data), 32'(8'h00));
        chk("rst_fault", 32'(fault), 32'(3'b000));
        chk("rst_agree", 32'(all_agree), 32'(0));

        drive(1'b1, {3{8'hA5}}, 1'b0, 1'b0);
        settle();
        chk("a5_valid", 32'(out_valid), 32'(1));
        chk("a5_major", 32'(major_data), 32'(8'hA5));
        chk("a5_agree", 32'(all_agree), 32'(1));
        drive(1'b0, 24'h0, 1'b0, 1'b0);
        settle();
        chk("a5_idle_valid", 32'(out_valid), 32'(0));
        chk("a5_hold", 32'(major_data), 32'(8'hA5));

        drive(1'b1, {8'h0F, 8'h00, 8'hFF}, 1'b0, 1'b0);
        settle();
        chk("mix_major", 32'(major_data), 32'(8'h0F));
        chk("mix_mm", 32'(mismatch), 32'(3'b011));
        chk("mix_fault", 32'(fault), 32'(3'b000));

        drive(1'b1, BAD, 1'b0, 1'b0);
        drive(1'b1, BAD, 1'b0, 1'b0);
        repeat (5) drive(1'b0, BAD, 1'b0, 1'b0);
        drive(1'b1, BAD, 1'b0, 1'b0);
        settle();
        chk("bad3_fault", 32'(fault), 32'(3'b000));
        drive(1'b1, BAD, 1'b0, 1'b0);
        settle();
        chk("bad4_fault", 32'(fault), 32'(3'b100));
        repeat (3) drive(1'b1, GOOD, 1'b0, 1'b0);
        settle();
        chk("sticky_fault", 32'(fault), 32'(3'b100));
        drive(1'b0, GOOD, 1'b1, 1'b0);
        settle();
        chk("clr_fault", 32'(fault), 32'(3'b000));

        repeat (3) drive(1'b1, BAD, 1'b0, 1'b0);
        drive(1'b1, GOOD, 1'b0, 1'b0);
        repeat (3) drive(1'b1, BAD, 1'b0, 1'b0);
        settle();
        chk("run_reset_fault", 32'(fault), 32'(3'b000));
        drive(1'b1, BAD, 1'b1, 1'b0);
        settle();
        chk("clrv_major", 32'(major_data), 32'(8'h3C));
        chk("clrv_fault", 32'(fault), 32'(3'b000));
        repeat (3) drive(1'b1, BAD, 1'b0, 1'b0);
        settle();
        chk("clrv_cnt0", 32'(fault), 32'(3'b000));
        drive(1'b1, BAD, 1'b0, 1'b0);
        settle();
        chk("refault", 32'(fault), 32'(3'b100));

        drive(1'b1, {8'hFF, 8'h0F, 8'hF0}, 1'b0, 1'b0);
        settle();
`ifdef MAJORITY_VOTER_MASK_EN
        chk("mask_tie", 32'(major_data), 32'(8'h3C));
`else
        chk("nomask_vote", 32'(major_data), 32'(8'hFF));
`endif

        drive(1'b1, 24'($urandom), 1'b0, 1'b0);
        drive(1'b1, 24'($urandom), 1'b0, 1'b1);
        settle();
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_fault", 32'(fault), 32'(3'b000));
        chk("mid_rst_major", 32'(major_data), 32'(8'h00));

        for (int k = 0; k < 600; k++) begin
            base = 8'($urandom);
            sick = $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) begin
                d[i*W +: W] = base;
                if (i == sick && $urandom_range(0, 9) < 7)
                    d[i*W +: W] = 8'($urandom);
                else if ($urandom_range(0, 9) == 0)
                    d[i*W +: W] = 8'($urandom);
            end
            drive($urandom_range(0, 3) != 0, d,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 149) == 0);
        end
        drive(1'b0, 24'h0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #3;
        chk("sb_drained", 32'(q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/majority_voter_n.md
Name: majority_voter_n

Overview:
- Parametrised, registered N-channel bitwise majority voter; successor to the 3-input combinational majority gate.
- Votes WIDTH-bit words from N_CH redundant channels and registers the result with a valid strobe.
- Tracks consecutive disagreements per channel and raises a sticky fault flag per channel.
- Sits downstream of replicated (TMR-style) datapaths, before consumer logic.

Parameters:
- N_CH, 3, number of voting channels; odd, >= 3.
- WIDTH, 8, bits per channel word.
- ERR_LIMIT, 4, consecutive mismatching valid samples that set a channel's fault flag; >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  ch_data holds a sample this cycle.
- ch_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- clr_fault  in  1  clears all fault flags and error counters.
- out_valid  out  1  major_data/mismatch valid this cycle.
- major_data  out  WIDTH  voted word.
- mismatch  out  N_CH  bit i set when channel i differed from the vote.
- all_agree  out  1  all channels equal for the registered sample.
- fault  out  N_CH  sticky per-channel fault.

Behaviour:
- Reset: rst sampled high at a clk edge clears all outputs and internal counters to 0. Reset mid-stream discards any in-flight sample. out_valid is 0 the cycle after rst deasserts.
- Vote: for each bit b, major_data[b] = 1 iff the count of channels with bit b = 1 is greater than N_CH/2 (integer division).
- Popcount width is $clog2(N_CH+1).
- Latency: 1 cycle. in_valid at edge k gives out_valid = 1 with major_data, mismatch and all_agree after edge k.
- No backpressure; every valid sample is accepted.
- in_valid = 0: out_valid = 0 next cycle. major_data, mismatch and all_agree hold their last values.
- mismatch[i] = (channel i word != voted word), computed from the same sample as the vote.
- all_agree = ~|mismatch.
- Error counters: one per channel, width $clog2(ERR_LIMIT+1). Updated only on in_valid cycles:
  - mismatch: increment, saturating at ERR_LIMIT.
  - match: clear to 0.
- Idle cycles leave counters unchanged.
- fault[i] is set on the same edge at which counter i reaches ERR_LIMIT, so it rises together with the out_valid of the ERR_LIMIT-th consecutive bad sample. It stays set until clr_fault or rst.
- clr_fault: all counters and faults go to 0 on the next edge.
  - If it coincides with in_valid, the clear wins: that sample is not counted.
  - The sample is still voted, and major_data, mismatch and out_valid update normally.
- clr_fault has no effect on out_valid, major_data, mismatch or all_agree.

Optional Feature:
- Macro: MAJORITY_VOTER_MASK_EN.
- Defined:
  - Channels with fault[i] = 1 are excluded from the vote.
  - Vote bit = 1 iff ones > active/2; an exact tie holds the previous major_data bit.
  - If active = 0, major_data holds and out_valid still pulses.
  - mismatch is still reported for masked channels.
- Undefined: all channels always vote; fault is report-only.

Decomposition:
- Shared package majority_pkg holds:
  - the function clog2 (or its equivalent);
  - default constants MAJ_N_CH_DEF = 3, MAJ_WIDTH_DEF = 8, MAJ_ERR_LIMIT_DEF = 4;
  - the channel-slice index macro/function.
- One natural sub-module, majority_bit: a combinational popcount-compare vote for one bit slice, with inputs votes[N_CH] and mask[N_CH]. It is instantiated WIDTH times via generate.
- Counters, faults and output registers stay in the top.

Test Plan (N_CH=3, WIDTH=8, ERR_LIMIT=4):
- rst high 2 cycles with random ch_data/in_valid -> out_valid=0, major_data=8'h00, mismatch=3'b000, fault=3'b000, all_agree=0.
- All channels 8'hA5, in_valid one cycle -> next cycle out_valid=1, major_data=8'hA5, mismatch=3'b000, all_agree=1; the following cycle out_valid=0 and major_data holds 8'hA5.
- ch0=8'hFF, ch1=8'h00, ch2=8'h0F -> major_data=8'h0F, mismatch=3'b011, all_agree=0, fault=3'b000.
- ch0=ch1=8'h3C, ch2=8'hC3:
  - 2 bad samples, 5 idle cycles, 2 more bad samples -> fault=3'b100 rises with the 4th out_valid.
  - Then 3 clean samples -> fault stays 3'b100.
  - Then clr_fault pulse -> fault=3'b000.
- 3 bad ch2 samples, then 1 clean sample, then 3 bad -> fault stays 3'b000. Then clr_fault coincident with a 4th bad sample -> sample voted (major_data=8'h3C), counter reads 0, fault=3'b000.
- With MAJORITY_VOTER_MASK_EN and fault=3'b100:
  - ch0=8'hF0, ch1=8'h0F, ch2=8'hFF, previous major=8'h3C -> tie on every bit, so major_data=8'h3C.
  - rst asserted mid-stream -> all state clears next edge.
